// File: rtl/video_stream_pkg.sv
// Shared types and defaults for the video stream transmitter.
package video_stream_pkg;

    localparam int unsigned IMAGE_W_DEFAULT = 640;
    localparam int unsigned IMAGE_H_DEFAULT = 480;
    localparam int unsigned CoordW          = 11;

    // Packet tracking states: between packets, inside a video frame, inside a control packet.
    typedef enum logic [1:0] {StIdle, StVideo, StCtrl} state_e;

    typedef logic [23:0] pixel_t;

    // One buffered beat: delimiters plus the {red, green, blue} word.
    typedef struct packed {
        logic   sop;
        logic   eop;
        pixel_t data;
    } beat_t;

    function automatic pixel_t pack_pixel(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with registered occupancy; read data is zero while empty.
module stream_fifo #(
    parameter int unsigned WIDTH = 26,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/video_stream_tx.sv
// Video/control packet framer: tracks packet position, tags eop, buffers beats for the sink.
module video_stream_tx
    import video_stream_pkg::*;
#(
    parameter int unsigned IMAGE_W    = IMAGE_W_DEFAULT,
    parameter int unsigned IMAGE_H    = IMAGE_H_DEFAULT,
    parameter int unsigned CTRL_BEATS = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sop,
    input  logic              in_packet_video,
    input  logic [7:0]        red,
    input  logic [7:0]        green,
    input  logic [7:0]        blue,
    output logic [23:0]       source_data,
    output logic              source_valid,
    input  logic              source_ready,
    output logic              source_sop,
    output logic              source_eop,
    output logic [CoordW-1:0] x,
    output logic [CoordW-1:0] y,
    output logic              frame_done,
    output logic              err_short
);

    localparam int unsigned       CntW     = (CTRL_BEATS > 1) ? $clog2(CTRL_BEATS) : 1;
    localparam logic [CoordW-1:0] LastX    = CoordW'(IMAGE_W - 1);
    localparam logic [CoordW-1:0] LastY    = CoordW'(IMAGE_H - 1);
    localparam logic [CntW-1:0]   LastBeat = CntW'(CTRL_BEATS - 1);

    state_e            state_q, state_d;
    logic [CoordW-1:0] x_q, x_d, y_q, y_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              frame_done_q, frame_done_d;
    logic              err_short_q, err_short_d;

    logic  accept, push, pop, fifo_empty, fifo_full;
    beat_t push_beat, pop_beat;

    assign in_ready     = !fifo_full;
    assign accept       = in_valid && in_ready;
    assign source_valid = !fifo_empty;
    assign pop          = source_valid && source_ready;
    assign source_data  = pop_beat.data;
    assign source_sop   = pop_beat.sop;
    assign source_eop   = pop_beat.eop;
    assign x            = x_q;
    assign y            = y_q;
    assign frame_done   = frame_done_q;
    assign err_short    = err_short_q;

    // Packet state, coordinates, control beat counter and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            x_q          <= '0;
            y_q          <= '0;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
            err_short_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
            err_short_q  <= err_short_d;
        end
    end

    // Next-state: classify each accepted beat, tag eop and decide whether it is buffered.
    always_comb begin
        state_d        = state_q;
        x_d            = x_q;
        y_d            = y_q;
        cnt_d          = cnt_q;
        err_short_d    = err_short_q;
        frame_done_d   = 1'b0;
        push           = 1'b0;
        push_beat.sop  = in_sop;
        push_beat.eop  = 1'b0;
        push_beat.data = pack_pixel(red, green, blue);

        if (accept) begin
            if (in_sop) begin
                // A header inside a packet truncates the old one; restart cleanly.
                if (state_q != StIdle) err_short_d = 1'b1;
                x_d     = '0;
                y_d     = '0;
                cnt_d   = in_packet_video ? CntW'(0) : CntW'(1);
                state_d = in_packet_video ? StVideo : StCtrl;
                push    = 1'b1;
            end else begin
                unique case (state_q)
                    StVideo: begin
                        push = 1'b1;
                        if (x_q == LastX && y_q == LastY) begin
                            push_beat.eop = 1'b1;
                            frame_done_d  = 1'b1;
                            x_d           = '0;
                            y_d           = '0;
                            state_d       = StIdle;
                        end else if (x_q == LastX) begin
                            x_d = '0;
                            y_d = y_q + CoordW'(1);
                        end else begin
                            x_d = x_q + CoordW'(1);
                        end
                    end
                    StCtrl: begin
                        push = 1'b1;
                        if (cnt_q == LastBeat) begin
                            push_beat.eop = 1'b1;
                            cnt_d         = '0;
                            state_d       = StIdle;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                    default: begin
                        // Stray beat between packets: consumed but not forwarded.
                        push = 1'b0;
                    end
                endcase
            end
        end
    end

    stream_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (push_beat),
        .pop     (pop),
        .rdata   (pop_beat),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

endmodule

// File: tb/tb_video_stream_tx.sv
// Self-checking bench: directed scenarios plus random traffic against a packet-level model.
module tb_video_stream_tx;

    localparam int unsigned W     = 8;
    localparam int unsigned H     = 4;
    localparam int unsigned CB    = 4;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0, in_sop = 1'b0, in_packet_video = 1'b0;
    logic [7:0]  red = '0, green = '0, blue = '0;
    logic        source_ready = 1'b0;
    logic        in_ready, source_valid, source_sop, source_eop, frame_done, err_short;
    logic [23:0] source_data;
    logic [10:0] x, y;

    always #5 clk = ~clk;

    video_stream_tx #(
        .IMAGE_W    (W),
        .IMAGE_H    (H),
        .CTRL_BEATS (CB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_sop          (in_sop),
        .in_packet_video (in_packet_video),
        .red             (red),
        .green           (green),
        .blue            (blue),
        .source_data     (source_data),
        .source_valid    (source_valid),
        .source_ready    (source_ready),
        .source_sop      (source_sop),
        .source_eop      (source_eop),
        .x               (x),
        .y               (y),
        .frame_done      (frame_done),
        .err_short       (err_short)
    );

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Packet-level model: mode 0 = between packets, 1 = video, 2 = control.
    // m_n counts pixels since a video header or beats since a control header.
    logic [25:0] mq[$];
    int          m_mode = 0;
    int          m_n = 0;
    bit          m_err = 0;
    bit          m_fd = 0;

    initial begin : model
        bit          acc;
        bit          do_pop;
        bit          eop;
        logic [23:0] pix;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                mq.delete();
                m_mode = 0;
                m_n    = 0;
                m_err  = 0;
                m_fd   = 0;
            end else begin
                acc    = in_valid && (mq.size() < DEPTH);
                do_pop = (mq.size() > 0) && source_ready;
                pix    = {red, green, blue};
                m_fd   = 0;
                if (do_pop) void'(mq.pop_front());
                if (acc) begin
                    if (in_sop) begin
                        if (m_mode != 0) m_err = 1;
                        m_mode = in_packet_video ? 1 : 2;
                        m_n    = 0;
                        mq.push_back({1'b1, 1'b0, pix});
                    end else if (m_mode == 1) begin
                        eop = (m_n == W * H - 1);
                        mq.push_back({1'b0, eop, pix});
                        if (eop) begin
                            m_fd   = 1;
                            m_mode = 0;
                            m_n    = 0;
                        end else begin
                            m_n++;
                        end
                    end else if (m_mode == 2) begin
                        eop = (m_n + 1 == CB - 1);
                        mq.push_back({1'b0, eop, pix});
                        if (eop) begin
                            m_mode = 0;
                            m_n    = 0;
                        end else begin
                            m_n++;
                        end
                    end
                end
            end
        end
    end

    int out_beats = 0;
    int out_eops = 0;
    int last_eop_at = 0;
    int fd_cnt = 0;

    // Every-cycle comparison against the model, sampled mid-cycle.
    initial begin : compare
        forever begin
            @(negedge clk);
            check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
            check("source_valid", 32'(source_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                check("source_data", 32'(source_data), 32'(mq[0][23:0]));
                check("source_sop", 32'(source_sop), 32'(mq[0][25]));
                check("source_eop", 32'(source_eop), 32'(mq[0][24]));
            end
            check("x", 32'(x), (m_mode == 1) ? 32'(m_n % W) : 32'd0);
            check("y", 32'(y), (m_mode == 1) ? 32'(m_n / W) : 32'd0);
            check("frame_done", 32'(frame_done), 32'(m_fd));
            check("err_short", 32'(err_short), 32'(m_err));
            if (source_valid && source_ready && reset_n) begin
                out_beats++;
                if (source_eop) begin
                    out_eops++;
                    last_eop_at = out_beats;
                end
            end
            if (frame_done) fd_cnt++;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit sop, input bit vid, input logic [23:0] pix);
        in_valid        = v;
        in_sop          = sop;
        in_packet_video = vid;
        {red, green, blue} = pix;
    endtask

    // Present one beat and hold it until accepted, with a bounded wait.
    task automatic send(input bit sop, input bit vid);
        drive(1'b1, sop, vid, 24'($urandom));
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                cycle();
                drive(1'b0, 1'b0, 1'b0, 24'h0);
                return;
            end
            cycle();
        end
        compared++;
        mismatched++;
        $display("FAIL send_timeout: beat not accepted within 200 cycles");
        drive(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    int base_b, base_e, base_f, acc_n;

    initial begin : stimulus
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cycle();

        // Reset values.
        check("rst_source_valid", 32'(source_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_source_word", 32'({source_sop, source_eop, source_data}), 32'd0);
        check("rst_xy", 32'({x, y}), 32'd0);
        check("rst_err_short", 32'(err_short), 32'd0);

        // Stray beats while idle are swallowed.
        source_ready = 1'b1;
        repeat (3) send(1'b0, 1'b1);
        repeat (3) cycle();
        check("idle_beats_out", 32'(out_beats), 32'd0);
        check("idle_x", 32'(x), 32'd0);
        check("idle_y", 32'(y), 32'd0);

        // One control packet.
        base_b = out_beats; base_e = out_eops; base_f = fd_cnt;
        send(1'b1, 1'b0);
        repeat (CB - 1) send(1'b0, 1'b0);
        repeat (4) cycle();
        check("ctrl_beats_out", 32'(out_beats - base_b), 32'(CB));
        check("ctrl_eops", 32'(out_eops - base_e), 32'd1);
        check("ctrl_eop_position", 32'(last_eop_at - base_b), 32'(CB));
        check("ctrl_frame_done", 32'(fd_cnt - base_f), 32'd0);

        // One full video frame.
        base_b = out_beats; base_e = out_eops; base_f = fd_cnt;
        send(1'b1, 1'b1);
        repeat (W * H) send(1'b0, 1'b1);
        repeat (6) cycle();
        check("frame_beats_out", 32'(out_beats - base_b), 32'(W * H + 1));
        check("frame_eops", 32'(out_eops - base_e), 32'd1);
        check("frame_eop_position", 32'(last_eop_at - base_b), 32'(W * H + 1));
        check("frame_done_count", 32'(fd_cnt - base_f), 32'd1);
        check("frame_end_xy", 32'({x, y}), 32'd0);

        // Backpressure: the buffer fills after exactly DEPTH accepts.
        source_ready = 1'b0;
        acc_n = 0;
        drive(1'b1, 1'b1, 1'b1, 24'($urandom));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_ready) acc_n++;
            cycle();
            drive(1'b1, 1'b0, 1'b1, 24'($urandom));
        end
        check("bp_accepts", 32'(acc_n), 32'(DEPTH));
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        source_ready = 1'b1;
        repeat (8) cycle();
        check("bp_drained", 32'(source_valid), 32'd0);
        check("bp_x", 32'(x), 32'd3);

        // Reset with beats buffered.
        source_ready = 1'b0;
        send(1'b1, 1'b1);
        send(1'b0, 1'b1);
        send(1'b0, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_source_valid", 32'(source_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cycle();
        check("rstmid_in_ready", 32'(in_ready), 32'd1);
        check("rstmid_err_short", 32'(err_short), 32'd0);
        source_ready = 1'b1;
        base_b = out_beats;
        send(1'b0, 1'b1);
        repeat (3) cycle();
        check("rstmid_idle_drop", 32'(out_beats - base_b), 32'd0);

        // Early sop truncates a video packet.
        base_e = out_eops;
        send(1'b1, 1'b1);
        repeat (5) send(1'b0, 1'b1);
        check("short_x_before", 32'(x), 32'd5);
        check("short_err_before", 32'(err_short), 32'd0);
        send(1'b1, 1'b1);
        repeat (3) cycle();
        check("short_err_after", 32'(err_short), 32'd1);
        check("short_x_after", 32'(x), 32'd0);
        check("short_no_eop", 32'(out_eops - base_e), 32'd0);
        repeat (W * H) send(1'b0, 1'b1);
        repeat (6) cycle();
        check("short_second_eop", 32'(out_eops - base_e), 32'd1);

        // Random traffic with one mid-cycle reset.
        for (int i = 0; i < 3000; i++) begin
            source_ready    = ($urandom_range(0, 3) != 0);
            in_valid        = ($urandom_range(0, 3) != 0);
            in_sop          = ($urandom_range(0, 59) == 0);
            in_packet_video = 1'($urandom_range(0, 1));
            {red, green, blue} = 24'($urandom);
            if (i == 1500) begin
                #2 reset_n = 1'b0;
                #5 reset_n = 1'b1;
            end
            cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        source_ready = 1'b1;
        repeat (10) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/video_stream_tx.md
VIDEO_STREAM_TX -- requirements
Module: video_stream_tx

Interface
REQ-001 Parameter IMAGE_W, default 640, pixels per line of a video packet.
REQ-002 Parameter IMAGE_H, default 480, lines per video packet.
REQ-003 Parameter CTRL_BEATS, default 4, total beats (header included) of a non-video packet.
REQ-004 Parameter FIFO_DEPTH, default 4, output buffer entries (power of two, >=2).
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  input  1  upstream beat present.
REQ-008 in_ready  output  1  block can accept a beat this cycle.
REQ-009 in_sop  input  1  beat is the packet header (start of packet).
REQ-010 in_packet_video  input  1  packet being started/continued is a video packet.
REQ-011 red, green, blue  input  8 each  processed pixel channels (header word on sop beats).
REQ-012 source_data  output  24  {red, green, blue} of the emitted beat.
REQ-013 source_valid  output  1  emitted beat present.
REQ-014 source_ready  input  1  downstream accepts the beat.
REQ-015 source_sop, source_eop  output  1 each  packet delimiters of the emitted beat.
REQ-016 x, y  output  11 each  coordinates the next accepted video pixel will take.
REQ-017 frame_done  output  1  one-cycle pulse when a video eop beat is accepted.
REQ-018 err_short  output  1  sticky flag: a packet was cut short by an early sop.

Function
REQ-019 A beat SHALL be accepted exactly when in_valid and in_ready are both high at a rising edge.
REQ-020 in_ready SHALL be high iff the FIFO occupancy register is below FIFO_DEPTH; it SHALL not depend combinationally on source_ready.
REQ-021 Each accepted beat SHALL push {sop, eop, red, green, blue} into the FIFO; a beat dropped per REQ-026 SHALL NOT push.
REQ-022 source_valid SHALL be high iff the FIFO is non-empty; a pop occurs when source_valid and source_ready are both high.
REQ-023 Latency: a beat accepted into an empty FIFO SHALL appear on source_* in the next cycle.
REQ-024 Simultaneous push and pop SHALL leave occupancy unchanged; order SHALL be strictly FIFO.
REQ-025 State machine states: IDLE, VIDEO, CTRL; reset state IDLE.
REQ-026 IDLE: a non-sop beat SHALL be accepted and discarded; a sop beat SHALL go to VIDEO if in_packet_video, else CTRL.
REQ-027 VIDEO: each non-sop beat SHALL advance x; at x = IMAGE_W-1, x SHALL wrap to 0 and y SHALL increment.
REQ-028 VIDEO: the beat at x = IMAGE_W-1, y = IMAGE_H-1 SHALL carry eop, pulse frame_done, clear x and y, and return to IDLE.
REQ-029 CTRL: a beat counter SHALL count from the header; beat CTRL_BEATS-1 SHALL carry eop and return to IDLE.
REQ-030 A sop accepted in VIDEO or CTRL SHALL set err_short, clear x, y and the beat counter, and start the new packet per REQ-026.
REQ-031 Sop beats SHALL never carry eop; x, y SHALL not advance on sop beats.

Reset
REQ-032 Reset SHALL empty the FIFO, set the state to IDLE, and clear x, y, counter, frame_done and err_short.
REQ-033 Reset SHALL drive source_valid low and in_ready high after release; source_data, source_sop and source_eop SHALL be 0.
REQ-034 Reset mid-packet SHALL discard buffered beats; no partial eop SHALL be emitted.

Structure
REQ-035 Package video_stream_pkg SHALL hold IMAGE_W/IMAGE_H defaults, the state enum and the 24-bit pixel beat typedef.
REQ-036 The buffer SHALL be a sub-module named stream_fifo, parameterised on width and depth.

Verification
REQ-037 Continuous sop, then 640x480 pixels, source_ready=1 -> 307201 beats out, eop only on beat 307201, frame_done once, y=0/x=0 after.
REQ-038 Non-video sop with CTRL_BEATS=4 -> 4 beats out, eop on the 4th, frame_done stays low.
REQ-039 source_ready held low, in_valid=1 -> in_ready drops after exactly 4 accepts; releasing it drains data in order with no loss.
REQ-040 Video packet with sop after 100 pixels -> err_short=1, x restarts at 0, no eop emitted for the first packet.
REQ-041 Three non-sop beats in IDLE -> accepted, nothing emitted, x=y=0.
REQ-042 reset_n pulsed low with 3 beats buffered -> source_valid=0 immediately, in_ready=1 and state IDLE after release.
